bus_demux: RTL
==============

// Module: bus_demux
// PURPOSE
//  - Splits one 12-bit producer stream across NUM_DEST consumer ports (datapath registers, address latches).
//  - Counterpart of the 2:1 select muxes that merge sources onto the 12-bit datapath.
//  - Each destination has a one-entry output register with a valid/ready handshake.
//  - A stalled consumer blocks only words addressed to it.
// PARAMETERS
//  WIDTH     12  data word width
//  NUM_DEST  3   number of destination ports (2..8)
//  DEST_W    $clog2(NUM_DEST)  width of destination select (derived, localparam)
// PORTS
//  clk        in   1                 single clock, all logic on posedge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 producer word valid
//  in_ready   out  1                 block accepts word this cycle
//  in_data    in   WIDTH             producer word
//  in_dest    in   DEST_W            destination index of in_data
//  out_valid  out  NUM_DEST          per-destination word valid
//  out_ready  in   NUM_DEST          per-destination consumer ready
//  out_data   out  NUM_DEST*WIDTH    packed; slot d at [d*WIDTH +: WIDTH]
//  dest_err   out  1                 pulse: word dropped, in_dest >= NUM_DEST
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, dest_err=0, counters=0. in_ready follows the combinational rule below.
//  - Transfer on the input side: in_valid && in_ready at posedge.
//  - in_ready is combinational from slot state and out_ready. No combinational path from in_data to in_ready.
//      - in_dest < NUM_DEST: in_ready = !out_valid[in_dest] || out_ready[in_dest].
//      - in_dest >= NUM_DEST: in_ready = 1. Word is discarded. dest_err = 1 for exactly the next cycle.
//  - Latency: an accepted word appears at out_data[d] with out_valid[d]=1 on the following cycle. There is no same-cycle bypass.
//  - Slot d per cycle, given load = accepted && in_dest==d and pop = out_valid[d] && out_ready[d]:
//      - load (with or without pop) -> out_valid[d]=1, out_data[d]=in_data. Full throughput is 1 word/cycle per slot.
//      - pop only -> out_valid[d]=0. out_data[d] holds its last value.
//      - neither -> hold.
//  - out_data[d] is stable while out_valid[d]=1 and out_ready[d]=0.
//  - out_valid never depends combinationally on out_ready.
//  - Slots are independent: a full, stalled slot never blocks words for other destinations.
//  - dest_err is registered, deasserts after one cycle, and reasserts for back-to-back bad words.
//  - in_valid=0: in_dest and in_data are ignored, and no slot or dest_err changes.
//  - Reset mid-operation: all held words are lost. No out_valid is asserted in the cycle after reset.
// CONFIGURATION
//  BUS_DEMUX_CNT_EN defined:
//    - Adds port deliv_cnt (out, NUM_DEST*8).
//    - Per-destination 8-bit count of completed output pops (out_valid && out_ready).
//    - Counters saturate at 8'hFF and clear on rst.
//  BUS_DEMUX_CNT_EN undefined:
//    - Neither the port nor the counter logic exists.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package bus_demux_pkg:
//      - WORD_W=12
//      - typedef logic [WORD_W-1:0] word_t
//      - MAX_DEST=8
//      - typedef logic [2:0] dest_t
//  - Sub-module demux_slot:
//      - One-entry valid/ready register (load, data, out_ready -> out_valid, out_data, slot_ready).
//      - Instantiated NUM_DEST times via generate.
//  - Top level holds the in_dest decode, the in_ready mux, dest_err and the optional counters.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, dest_err=0; after release in_ready=1 for dest 0.
//  2. Single word: in_data=12'hA5C, in_dest=1, out_ready=3'b000 -> cycle+1 out_valid=3'b010, out_data[1]=12'hA5C held until out_ready[1]=1.
//  3. Backpressure isolation: slot 1 full and stalled -> in_ready=0 for dest 1, in_ready=1 for dest 2; word 12'h123 to dest 2 delivered next cycle.
//  4. Simultaneous pop+load: slot 0 holds 12'h001 with out_ready[0]=1; load 12'h002 to dest 0 -> next cycle out_valid[0]=1, out_data[0]=12'h002, no bubble; 8 streamed words arrive in order.
//  5. Bad destination: NUM_DEST=3, in_dest=3, in_valid=1 -> in_ready=1, dest_err=1 for one cycle, all out_valid unchanged.
//  6. With BUS_DEMUX_CNT_EN: 300 pops on dest 2 -> deliv_cnt[2]=8'hFF, others 0; rst clears to 0.

Source files
------------

// File: rtl/bus_demux_pkg.sv
// ---------------------------------------------------------------------------
// bus_demux_pkg
// Shared types and constants for the bus_demux block (one producer stream
// fanned out to up to MAX_DEST one-entry consumer registers).
//
// Contents:
//   WORD_W    default datapath word width
//   word_t    one datapath word
//   MAX_DEST  largest supported number of destinations
//   dest_t    widest destination index (covers MAX_DEST)
//   CNT_W     width of one delivery counter
//   sat_inc   saturating increment for delivery counters
// ---------------------------------------------------------------------------
package bus_demux_pkg;

  localparam int WORD_W   = 12;
  localparam int MAX_DEST = 8;
  localparam int CNT_W    = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        dest_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Counts stick at all-ones instead of wrapping, so a long-running count
  // reads as "at least 255" rather than a misleading small number.
  function automatic cnt_t sat_inc(input cnt_t c);
    cnt_t r;
    if (c == {CNT_W{1'b1}}) r = c;
    else                    r = c + cnt_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/bus_demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry output register with a valid/ready handshake. One instance per
// destination of bus_demux.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   load       in   capture data this cycle (top guarantees slot_ready=1)
//   data       in   WIDTH  word to capture
//   out_ready  in   consumer ready
//   out_valid  out  register holds a word
//   out_data   out  WIDTH  held word (stable while out_valid && !out_ready)
//   slot_ready out  slot can take a word this cycle (empty, or being popped)
//
// Handshake: a word moves when valid and ready are both 1 at posedge; valid
// never depends on ready in the same cycle, and data/valid hold while
// valid=1 and ready=0.
// ---------------------------------------------------------------------------
module demux_slot
  import bus_demux_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             slot_ready
);

  logic pop;

  assign pop        = out_valid && out_ready;
  // A pop frees the entry at the same edge, so a load can land behind it
  // without a bubble.
  assign slot_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (pop) begin
      // Data keeps its last value after a pop; only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_demux.sv
// ---------------------------------------------------------------------------
// bus_demux
// Splits one WIDTH-bit producer stream across NUM_DEST consumer ports, each
// backed by a one-entry register (demux_slot). A stalled consumer blocks only
// words addressed to it. Words with an out-of-range destination are accepted,
// dropped and flagged on dest_err for one cycle.
//
// Parameters:
//   WIDTH     data word width (default 12)
//   NUM_DEST  number of destinations, 2..MAX_DEST (default 3)
//   DEST_W    derived: $clog2(NUM_DEST)
//
// Ports:
//   clk        in   single clock, posedge
//   rst        in   synchronous active-high reset
//   in_valid   in   producer word valid
//   in_ready   out  word accepted this cycle (combinational from slot state,
//                   out_ready and in_dest; never from in_data)
//   in_data    in   WIDTH producer word
//   in_dest    in   DEST_W destination index of in_data
//   out_valid  out  NUM_DEST per-destination valid
//   out_ready  in   NUM_DEST per-destination consumer ready
//   out_data   out  NUM_DEST*WIDTH, slot d at [d*WIDTH +: WIDTH]
//   dest_err   out  one-cycle pulse after a word with in_dest >= NUM_DEST
//   deliv_cnt  out  NUM_DEST*8, only when BUS_DEMUX_CNT_EN is defined:
//                   per-destination saturating count of completed pops
//
// Build option: BUS_DEMUX_CNT_EN adds deliv_cnt and its counters.
//
// Handshake (both sides): a transfer happens when valid && ready at posedge.
// Accepted words appear at the destination on the next cycle; there is no
// same-cycle bypass.
// ---------------------------------------------------------------------------
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter  int WIDTH    = WORD_W,
  parameter  int NUM_DEST = 3,
  localparam int DEST_W   = $clog2(NUM_DEST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [DEST_W-1:0]         in_dest,
  output logic [NUM_DEST-1:0]       out_valid,
  input  logic [NUM_DEST-1:0]       out_ready,
  output logic [NUM_DEST*WIDTH-1:0] out_data,
  output logic                      dest_err
`ifdef BUS_DEMUX_CNT_EN
  ,
  output logic [NUM_DEST*CNT_W-1:0] deliv_cnt
`endif
);

  logic                dest_ok;
  logic                sel_ready;
  logic                accept;
  logic [NUM_DEST-1:0] slot_ready;
  logic [NUM_DEST-1:0] load;

  // Destination decode and ready mux. The index is widened to int so an
  // out-of-range code (possible when NUM_DEST is not a power of two) never
  // selects a nonexistent slot; such words see ready=1 and are dropped.
  always_comb begin
    dest_ok   = (int'(in_dest) < NUM_DEST);
    sel_ready = 1'b1;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (int'(in_dest) == d) sel_ready = slot_ready[d];
    end
  end

  assign in_ready = sel_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      load[d] = accept && dest_ok && (int'(in_dest) == d);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DEST; g++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load[g]),
        .data       (in_data),
        .out_ready  (out_ready[g]),
        .out_valid  (out_valid[g]),
        .out_data   (out_data[g*WIDTH +: WIDTH]),
        .slot_ready (slot_ready[g])
      );
    end
  endgenerate

  // Registered, so it pulses for exactly the cycle after each bad word and
  // stays high across back-to-back bad words.
  always_ff @(posedge clk) begin
    if (rst) dest_err <= 1'b0;
    else     dest_err <= in_valid && !dest_ok;
  end

`ifdef BUS_DEMUX_CNT_EN
  generate
    for (g = 0; g < NUM_DEST; g++) begin : g_cnt
      cnt_t cnt;

      always_ff @(posedge clk) begin
        if (rst)                              cnt <= '0;
        else if (out_valid[g] && out_ready[g]) cnt <= sat_inc(cnt);
      end

      assign deliv_cnt[g*CNT_W +: CNT_W] = cnt;
    end
  endgenerate
`endif

endmodule
